csel_pipe_adder: RTL and testbench
==================================

Name: csel_pipe_adder

Overview:
- Parametrised, two-stage pipelined carry-select adder/subtractor with valid/ready handshakes on input and output.
- Operands are split into BLOCK-bit groups. Stage 1 computes each group's sum and carry for carry-in 0 and for carry-in 1. Stage 2 resolves the group carry chain by selection and registers the result.
- Used as the generic wide adder in datapaths; it replaces hand-wired single-bit full-adder chains.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be ≥ 2 and an exact multiple of BLOCK.
- BLOCK, 4, carry-select group width in bits. Must be ≥ 1. NBLK = WIDTH/BLOCK.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand set is valid this cycle.
- in_ready  output  1  block accepts an operand set this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0 = A+B+cin; 1 = A−B, computed as A+~B+1.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB. In sub mode, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk). While rst_n=0 at an edge:
  - s1_valid and s2_valid are cleared, so out_valid=0.
  - sum=0, cout=0, ovf=0, and all stage-1 data registers are 0.
  - in_ready reads 1 in the cycle after reset releases.
- Transfers:
  - Input transfer occurs when in_valid & in_ready at an edge.
  - Output transfer occurs when out_valid & out_ready at an edge.
- Stage 1 (registered on input transfer):
  - bb = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
  - For group k = 0..NBLK−1, store sum0_k/carry0_k (group carry-in 0) and sum1_k/carry1_k (group carry-in 1).
  - Group 0 uses only c0; its "1" copy is don't-care.
  - Also store the operand sign bits a[MSB] and bb[MSB].
- Stage 2 (registered when stage 1 advances):
  - Group carry chain: c_{k+1} = c_k ? carry1_k : carry0_k; group k output = c_k ? sum1_k : sum0_k.
  - cout = c_NBLK.
  - ovf = (a_msb == bb_msb) & (sum_msb != a_msb).
- Latency: a result appears at out_valid exactly 2 cycles after its input transfer, provided out_ready has not stalled it.
- Pipeline control:
  - s2_adv = s1_valid & (~s2_valid | out_ready).
  - in_ready = ~s1_valid | s2_adv. This is combinational from out_ready; there is no other input-to-output combinational path.
  - s1_valid next = input transfer | (s1_valid & ~s2_adv).
  - s2_valid next = s2_adv | (s2_valid & ~out_ready).
- Throughput: 1 result per cycle while out_ready=1. The pipeline holds at most 2 operand sets.
- Stall: with out_ready=0 and both stages full, in_ready=0. sum/cout/ovf and out_valid hold stable until the output transfer. No data is lost, duplicated or reordered.
- Simultaneous input and output transfer in the same cycle is legal and keeps full throughput.
- While in_valid=0, data-register contents are don't-care but must not alter the held outputs.
- Reset asserted mid-operation discards all in-flight operands. No stale result ever appears after reset.
- Wrap-around: sum is truncated to WIDTH bits; the carry is reported only on cout.
- Degenerate case BLOCK=WIDTH: NBLK=1 and the block behaves as a registered ripple adder with the same latency.

Test Plan:
- WIDTH=16/BLOCK=4, add a=0xFFFF b=0x0001 cin=0 -> 2 cycles later sum=0x0000 cout=1 ovf=0.
- Add a=0x7FFF b=0x0001 cin=0 -> sum=0x8000 cout=0 ovf=1. Add a=0x00F0 b=0x000F cin=1 -> sum=0x0100 cout=0 ovf=0 (carry crosses groups 1→2).
- Sub a=0x0005 b=0x0007 cin=1 -> sum=0xFFFE cout=0 ovf=0 (cin ignored). Sub a=0x8000 b=0x0001 -> sum=0x7FFF cout=1 ovf=1.
- Stream of 3 adds (1+1, 2+2, 3+3) with out_ready=0:
  - in_ready falls after 2 transfers.
  - Raise out_ready -> outputs 0x0002, 0x0004, 0x0006 in order, one per cycle. None lost.
- Continuous in_valid=1 and out_ready=1 for 8 random vectors -> 8 results on consecutive cycles, each equal to a reference model (a+b+cin) mod 2^16.
- Pulse rst_n=0 for 1 cycle with both stages full -> next cycle out_valid=0, sum=0, cout=0, ovf=0, in_ready=1. A new operand afterwards yields its correct result 2 cycles after acceptance.

Source files
------------

// File: rtl/csel_pipe_adder.sv
// csel_pipe_adder
// Two-stage pipelined carry-select adder/subtractor with valid/ready flow control.
//
// Stage 1 splits the operands into BLOCK-bit groups. For each group it registers
// two candidate sums and carries: one for a group carry-in of 0 and one for 1.
// Stage 2 walks the group carry chain and selects one candidate per group, then
// registers the final result.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand set presented this cycle
//   in_ready   block accepts an operand set this cycle (combinational from out_ready)
//   a, b       operands (WIDTH bits)
//   cin        carry-in for add; ignored when sub=1
//   sub        0: a+b+cin, 1: a-b (computed as a+~b+1)
//   out_valid  result registers hold a valid result
//   out_ready  consumer accepts the result this cycle
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB (in sub mode 1 means no borrow)
//   ovf        two's-complement signed overflow
//
// WIDTH must be >= 2 and an exact multiple of BLOCK; BLOCK must be >= 1.
module csel_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NBLK = WIDTH / BLOCK;

  // Operand conditioning: subtraction is a + ~b + 1, so sub forces the carry-in.
  logic [WIDTH-1:0] bb;
  logic             c0;

  assign bb = sub ? ~b : b;
  assign c0 = sub | cin;

  // Per-group candidate sums, one extra bit holding the group carry-out.
  logic [BLOCK:0] grp0 [NBLK];
  logic [BLOCK:0] grp1 [NBLK];

  for (genvar k = 0; k < NBLK; k++) begin : g_grp
    logic cin_lo;
    logic cin_hi;

    // Group 0 sees the real carry-in, so both of its copies use c0; the
    // chain in stage 2 always picks the "0" copy for group 0 anyway.
    if (k == 0) begin : g_first
      assign cin_lo = c0;
      assign cin_hi = c0;
    end else begin : g_rest
      assign cin_lo = 1'b0;
      assign cin_hi = 1'b1;
    end

    assign grp0[k] = {1'b0, a[k*BLOCK +: BLOCK]} + {1'b0, bb[k*BLOCK +: BLOCK]}
                   + {{BLOCK{1'b0}}, cin_lo};
    assign grp1[k] = {1'b0, a[k*BLOCK +: BLOCK]} + {1'b0, bb[k*BLOCK +: BLOCK]}
                   + {{BLOCK{1'b0}}, cin_hi};
  end

  // Pipeline control
  logic s1_valid;
  logic s2_valid;
  logic s2_adv;
  logic in_xfer;

  assign s2_adv    = s1_valid & (~s2_valid | out_ready);
  assign in_ready  = ~s1_valid | s2_adv;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = s2_valid;

  // Stage 1 registers
  logic [NBLK-1:0][BLOCK-1:0] s1_sum0;
  logic [NBLK-1:0][BLOCK-1:0] s1_sum1;
  logic [NBLK-1:0]            s1_carry0;
  logic [NBLK-1:0]            s1_carry1;
  logic                       s1_a_msb;
  logic                       s1_bb_msb;

  // Stage 1 loads only on an input transfer; in_ready guarantees the previous
  // contents are either empty or moving into stage 2 on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sum0   <= '0;
      s1_sum1   <= '0;
      s1_carry0 <= '0;
      s1_carry1 <= '0;
      s1_a_msb  <= 1'b0;
      s1_bb_msb <= 1'b0;
    end else begin
      s1_valid <= in_xfer | (s1_valid & ~s2_adv);
      if (in_xfer) begin
        for (int k = 0; k < NBLK; k++) begin
          s1_sum0[k]   <= grp0[k][BLOCK-1:0];
          s1_carry0[k] <= grp0[k][BLOCK];
          s1_sum1[k]   <= grp1[k][BLOCK-1:0];
          s1_carry1[k] <= grp1[k][BLOCK];
        end
        s1_a_msb  <= a[WIDTH-1];
        s1_bb_msb <= bb[WIDTH-1];
      end
    end
  end

  // Stage 2 carry-select chain. Group 0 already absorbed the real carry-in,
  // so the chain starts at 0 and picks the "0" copy for it.
  logic [WIDTH-1:0] sel_sum;
  logic             chain_c;
  logic             sel_ovf;

  always_comb begin
    sel_sum = '0;
    chain_c = 1'b0;
    for (int k = 0; k < NBLK; k++) begin
      sel_sum[k*BLOCK +: BLOCK] = chain_c ? s1_sum1[k] : s1_sum0[k];
      chain_c                   = chain_c ? s1_carry1[k] : s1_carry0[k];
    end
    sel_ovf = (s1_a_msb == s1_bb_msb) & (sel_sum[WIDTH-1] != s1_a_msb);
  end

  // Stage 2 registers only change when stage 1 advances, so a stalled result
  // stays stable until it is consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      s2_valid <= s2_adv | (s2_valid & ~out_ready);
      if (s2_adv) begin
        sum  <= sel_sum;
        cout <= chain_c;
        ovf  <= sel_ovf;
      end
    end
  end

endmodule

// File: tb/tb_csel_pipe_adder.sv
// Testbench for csel_pipe_adder (WIDTH=16, BLOCK=4).
// A queue-based reference model predicts every result from plain integer
// arithmetic; a negedge process compares the DUT against it each cycle.
// Directed vectors with literal expectations pin the model.
module tb_csel_pipe_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  csel_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          rc;
  } exp_t;

  exp_t        model_q[$];
  logic [15:0] out_log[$];
  int          out_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  bit          armed  = 1'b0;

  always @(posedge clk) cyc++;

  // Expected result straight from integer arithmetic.
  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                 input logic cv, input logic sv);
    exp_t e;
    int   t;
    int   sr;
    if (!sv) begin
      t  = int'(av) + int'(bv) + int'(cv);
      e.c = (t > 65535);
      sr = int'($signed(av)) + int'($signed(bv)) + int'(cv);
    end else begin
      t  = int'(av) - int'(bv);
      e.c = (av >= bv);
      sr = int'($signed(av)) - int'($signed(bv));
    end
    e.s  = 16'(t);
    e.o  = (sr > 32767) || (sr < -32768);
    e.rc = 0;
    return e;
  endfunction

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, then advance the model with the
  // transfers that the coming edge will perform.
  always @(negedge clk) begin
    if (armed) begin
      exp_t f;
      bit   exp_ov;
      exp_ov = (model_q.size() > 0) && (model_q[0].rc <= cyc);
      check1("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
      check1("in_ready", {31'b0, in_ready},
             {31'b0, !(model_q.size() == 2 && !out_ready)});
      if (out_valid && model_q.size() > 0) begin
        f = model_q[0];
        check1("model sum",  {16'b0, sum},  {16'b0, f.s});
        check1("model cout", {31'b0, cout}, {31'b0, f.c});
        check1("model ovf",  {31'b0, ovf},  {31'b0, f.o});
      end
      if (!rst_n) begin
        model_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          out_log.push_back(sum);
          out_cyc.push_back(cyc);
          if (model_q.size() > 0) void'(model_q.pop_front());
        end
        if (in_valid && in_ready) begin
          f = model(a, b, cin, sub);
          f.rc = cyc + 2;
          model_q.push_back(f);
        end
      end
    end
  end

  // Present one operand set and hold it until accepted. Called and returns
  // just after a rising edge.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                               input logic cv, input logic sv);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    cin = cv;
    sub = sv;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("[TB] FAIL accept timeout: got in_ready=0, expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for a valid result and compare it against literals.
  // Returns just after a rising edge.
  task automatic checkOutput(input string name, input logic [15:0] es,
                             input logic ec, input logic eo);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: got out_valid=0, expected 1 within 20 cycles", name);
    end else begin
      check1({name, " sum"},  {16'b0, sum},  {16'b0, es});
      check1({name, " cout"}, {31'b0, cout}, {31'b0, ec});
      check1({name, " ovf"},  {31'b0, ovf},  {31'b0, eo});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    armed = 1'b1;

    // Reset state
    @(negedge clk);
    check1("reset out_valid", {31'b0, out_valid}, 32'd0);
    check1("reset sum",       {16'b0, sum},       32'd0);
    check1("reset cout",      {31'b0, cout},      32'd0);
    check1("reset ovf",       {31'b0, ovf},       32'd0);
    check1("reset in_ready",  {31'b0, in_ready},  32'd1);
    @(posedge clk);
    #1;

    // Directed single operations
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    checkOutput("add wrap", 16'h0000, 1'b1, 1'b0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    checkOutput("add ovf", 16'h8000, 1'b0, 1'b1);
    applyStimulus(16'h00F0, 16'h000F, 1'b1, 1'b0);
    checkOutput("add group carry", 16'h0100, 1'b0, 1'b0);
    applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1);
    checkOutput("sub borrow", 16'hFFFE, 1'b0, 1'b0);
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1);
    checkOutput("sub ovf", 16'h7FFF, 1'b1, 1'b1);

    // Stall: fill both stages with out_ready low
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    base = out_log.size();
    applyStimulus(16'd1, 16'd1, 1'b0, 1'b0);
    applyStimulus(16'd2, 16'd2, 1'b0, 1'b0);
    in_valid = 1'b1;
    a = 16'd3;
    b = 16'd3;
    cin = 1'b0;
    sub = 1'b0;
    repeat (2) @(negedge clk);
    check1("stall in_ready", {31'b0, in_ready}, 32'd0);
    check1("stall held sum", {16'b0, sum},      32'd2);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(16'd3, 16'd3, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check1("stream count", out_log.size() - base, 32'd3);
    if (out_log.size() >= base + 3) begin
      check1("stream 1st", {16'b0, out_log[base]},     32'h0002);
      check1("stream 2nd", {16'b0, out_log[base + 1]}, 32'h0004);
      check1("stream 3rd", {16'b0, out_log[base + 2]}, 32'h0006);
      check1("stream back-to-back", out_cyc[base + 2] - out_cyc[base], 32'd2);
    end

    // Full throughput with random vectors
    base = out_log.size();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    end
    repeat (4) @(posedge clk);
    #1;
    check1("burst count", out_log.size() - base, 32'd8);
    if (out_log.size() >= base + 8) begin
      check1("burst consecutive", out_cyc[base + 7] - out_cyc[base], 32'd7);
    end

    // Reset with both stages full
    out_ready = 1'b0;
    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
    applyStimulus(16'h4321, 16'h0101, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check1("midreset out_valid", {31'b0, out_valid}, 32'd0);
    check1("midreset sum",       {16'b0, sum},       32'd0);
    check1("midreset cout",      {31'b0, cout},      32'd0);
    check1("midreset ovf",       {31'b0, ovf},       32'd0);
    check1("midreset in_ready",  {31'b0, in_ready},  32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(16'h0A0A, 16'h0505, 1'b1, 1'b0);
    checkOutput("after reset", 16'h0F10, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
